// File: rtl/single_port_rom_pkg.sv
// Shared constants and the reference formula for the 64x8 lookup ROM.
package single_port_rom_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;

    // Table entry: (addr*addr + 0x11) mod 256, squared in 12 bits before truncation
    function automatic logic [DATA_W-1:0] rom_value(input logic [ADDR_W-1:0] addr);
        logic [11:0] wide;
        wide = ({6'b0, addr} * {6'b0, addr}) + 12'h011;
        return wide[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/single_port_rom_table.sv
// Combinational 64-entry lookup; entries are (i*i + 0x11) mod 256.
module single_port_rom_table
    import single_port_rom_pkg::*;
(
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] word
);

    // Explicit case table so synthesis maps it straight to LUTs/ROM
    always_comb begin
        case (a)
            6'd0:  word = 8'h11;  6'd1:  word = 8'h12;
            6'd2:  word = 8'h15;  6'd3:  word = 8'h1A;
            6'd4:  word = 8'h21;  6'd5:  word = 8'h2A;
            6'd6:  word = 8'h35;  6'd7:  word = 8'h42;
            6'd8:  word = 8'h51;  6'd9:  word = 8'h62;
            6'd10: word = 8'h75;  6'd11: word = 8'h8A;
            6'd12: word = 8'hA1;  6'd13: word = 8'hBA;
            6'd14: word = 8'hD5;  6'd15: word = 8'hF2;
            6'd16: word = 8'h11;  6'd17: word = 8'h32;
            6'd18: word = 8'h55;  6'd19: word = 8'h7A;
            6'd20: word = 8'hA1;  6'd21: word = 8'hCA;
            6'd22: word = 8'hF5;  6'd23: word = 8'h22;
            6'd24: word = 8'h51;  6'd25: word = 8'h82;
            6'd26: word = 8'hB5;  6'd27: word = 8'hEA;
            6'd28: word = 8'h21;  6'd29: word = 8'h5A;
            6'd30: word = 8'h95;  6'd31: word = 8'hD2;
            6'd32: word = 8'h11;  6'd33: word = 8'h52;
            6'd34: word = 8'h95;  6'd35: word = 8'hDA;
            6'd36: word = 8'h21;  6'd37: word = 8'h6A;
            6'd38: word = 8'hB5;  6'd39: word = 8'h02;
            6'd40: word = 8'h51;  6'd41: word = 8'hA2;
            6'd42: word = 8'hF5;  6'd43: word = 8'h4A;
            6'd44: word = 8'hA1;  6'd45: word = 8'hFA;
            6'd46: word = 8'h55;  6'd47: word = 8'hB2;
            6'd48: word = 8'h11;  6'd49: word = 8'h72;
            6'd50: word = 8'hD5;  6'd51: word = 8'h3A;
            6'd52: word = 8'hA1;  6'd53: word = 8'h0A;
            6'd54: word = 8'h75;  6'd55: word = 8'hE2;
            6'd56: word = 8'h51;  6'd57: word = 8'hC2;
            6'd58: word = 8'h35;  6'd59: word = 8'hAA;
            6'd60: word = 8'h21;  6'd61: word = 8'h9A;
            6'd62: word = 8'h15;  6'd63: word = 8'h92;
            // Only reachable with X/Z on the address; propagate unknown
            default: word = 'x;
        endcase
    end

endmodule

// File: rtl/single_port_rom.sv
// 64x8 synchronous ROM: combinational table followed by a registered output.
module single_port_rom
    import single_port_rom_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] d
);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] d_d;
    logic [DATA_W-1:0] d_q;

    single_port_rom_table u_table (
        .a    (a),
        .word (word)
    );

    // Read every cycle; no enable
    always_comb begin
        d_d = word;
    end

    // Output register, cleared asynchronously so reset discards any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= '0;
        else        d_q <= d_d;
    end

    assign d = d_q;

endmodule

// File: tb/tb_single_port_rom.sv
// Directed bench for single_port_rom: reset, latency, sweep, hold/wrap,
// mid-stream reset and between-edge address changes.
module tb_single_port_rom;
    import single_port_rom_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    int n_chk = 0;
    int n_err = 0;

    single_port_rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Safety net against a stalled run
    initial begin
        #100us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with clock running
        rst_n = 1'b0;
        a     = 6'd5;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", d, 8'h00);
        end

        // Release and first-read latency
        rst_n = 1'b1;
        a     = 6'd0;
        @(negedge clk); chk("lat_a0", d, 8'h11);
        a = 6'd1;
        @(negedge clk); chk("lat_a1", d, 8'h12);
        a = 6'd2;
        @(negedge clk); chk("lat_a2", d, 8'h15);

        // Full sweep against formula plus hand-computed spot values
        for (int i = 0; i < DEPTH; i++) begin
            a = i[ADDR_W-1:0];
            @(negedge clk);
            chk("sweep", d, rom_value(i[ADDR_W-1:0]));
            if (i == 5)  chk("spot5",  d, 8'h2A);
            if (i == 15) chk("spot15", d, 8'hF2);
            if (i == 16) chk("spot16", d, 8'h11);
            if (i == 39) chk("spot39", d, 8'h02);
            if (i == 63) chk("spot63", d, 8'h92);
        end

        // Hold at 63, then wrap to 0
        a = 6'd63;
        repeat (5) begin
            @(negedge clk);
            chk("hold63", d, 8'h92);
        end
        a = 6'd0;
        @(negedge clk); chk("wrap0", d, 8'h11);

        // Sweep up to 31, then reset at a=32
        for (int i = 0; i < 32; i++) begin
            a = i[ADDR_W-1:0];
            @(negedge clk);
            chk("sweep2", d, rom_value(i[ADDR_W-1:0]));
        end
        chk("pre_rst31", d, 8'hD2);
        a     = 6'd32;
        rst_n = 1'b0;
        #1 chk("rst_async_clear", d, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid", d, 8'h00);
        end
        rst_n = 1'b1;
        @(negedge clk); chk("rel_a32", d, 8'h11);

        // Address toggles between edges must not reach d
        a = 6'd5;
        @(negedge clk); chk("pre_toggle", d, 8'h2A);
        @(posedge clk);
        #2 a = 6'd15;
        #2 a = 6'd16;
        #1 chk("between_edges", d, 8'h2A);
        a = 6'd63;
        @(posedge clk);
        #1 chk("after_edge", d, 8'h92);

        // Asynchronous reset mid-cycle clears without an edge
        #2 rst_n = 1'b0;
        #1 chk("async_midcycle", d, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        a     = 6'd7;
        @(negedge clk); chk("post_rel_a7", d, 8'h42);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
